mem_port_scheduler: RTL and testbench

Sequences the single data-memory port of the out-of-order core between two requesters: loads issued by the load/store queue once their address is resolved, and stores released at retirement. Retired stores are buffered in an internal committed-store FIFO and drained in order; loads are favoured for latency, but a watermark, an address hazard check and an optional aging counter force store drains. The block sits between Load_Store_Queue / retire logic and the data memory, and returns load results to the writeback/ROB path.

---
 rtl/mem_sched_pkg.sv | 19 +
 rtl/store_commit_fifo.sv | 76 +++++++
 rtl/mem_port_scheduler.sv | 176 +++++++++++++++++
 tb/tb_mem_port_scheduler.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types for the data-memory port scheduler: FSM states, committed-store entry, size codes.
package mem_sched_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoadWait,
      StStoreWait
   } sched_state_e;

   localparam logic MEM_SIZE_WORD = 1'b0;
   localparam logic MEM_SIZE_BYTE = 1'b1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        size;
   } store_entry_t;

endpackage

// File: rtl/store_commit_fifo.sv
// Committed-store FIFO: two write lanes per cycle (lane 0 older), one in-order read.
module store_commit_fifo
   import mem_sched_pkg::*;
#(
   parameter int unsigned SB_DEPTH = 8,
   localparam int unsigned PtrW = $clog2(SB_DEPTH),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [1:0]                 push_valid,
   input  store_entry_t               push_entry0,
   input  store_entry_t               push_entry1,
   input  logic                       pop,
   output store_entry_t               head,
   output logic [CntW-1:0]            count,
   output logic                       push_ready,
   output logic [SB_DEPTH-1:0]        entry_valid,
   output logic [SB_DEPTH-1:0][31:0]  entry_addr
);

   store_entry_t        mem_q [SB_DEPTH];
   logic [SB_DEPTH-1:0] valid_q, valid_d;
   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, slot1;
   logic [CntW-1:0]     count_q, count_d;
   logic                we0, we1, pop_ok;
   logic [1:0]          n_push;

   // Two free slots are required so a dual-lane retire can never overflow.
   assign push_ready = (count_q <= CntW'(SB_DEPTH - 2));
   assign pop_ok     = pop && (count_q != '0);

   always_comb begin
      we0      = push_ready && push_valid[0];
      we1      = push_ready && push_valid[1];
      slot1    = push_valid[0] ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      n_push   = {1'b0, we0} + {1'b0, we1};
      valid_d  = valid_q;
      if (we0) valid_d[wr_ptr_q] = 1'b1;
      if (we1) valid_d[slot1] = 1'b1;
      if (pop_ok) valid_d[rd_ptr_q] = 1'b0;
      wr_ptr_d = wr_ptr_q + PtrW'(n_push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
      count_d  = count_q + CntW'(n_push) - CntW'(pop_ok);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we0) mem_q[wr_ptr_q] <= push_entry0;
      if (we1) mem_q[slot1] <= push_entry1;
   end

   always_comb begin
      for (int i = 0; i < SB_DEPTH; i++) begin
         entry_addr[i] = mem_q[i].addr;
      end
   end

   assign head        = mem_q[rd_ptr_q];
   assign count       = count_q;
   assign entry_valid = valid_q;

endmodule

// File: rtl/mem_port_scheduler.sv
// Arbitrates the data-memory port between resolved loads and retired stores.
// Optional store aging is compiled in with `define MEMSCHED_AGING_EN.
module mem_port_scheduler
   import mem_sched_pkg::*;
#(
   parameter int unsigned SB_DEPTH  = 8,
   parameter int unsigned HIGH_WM   = 6,
   parameter int unsigned AGE_LIMIT = 4,
   localparam int unsigned CntW = $clog2(SB_DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            ldValid,
   input  logic [31:0]     ldPc,
   input  logic [31:0]     ldAddr,
   input  logic [5:0]      ldROBNum,
   input  logic [5:0]      ldDestReg,
   output logic            ldReady,
   input  logic [1:0]      stRetValid,
   input  logic [31:0]     stRetAddr0,
   input  logic [31:0]     stRetAddr1,
   input  logic [31:0]     stRetData0,
   input  logic [31:0]     stRetData1,
   input  logic            stRetSize0,
   input  logic            stRetSize1,
   output logic            stRetReady,
   output logic            memReq,
   output logic            memWe,
   output logic [31:0]     memAddr,
   output logic [31:0]     memWData,
   output logic            memSize,
   input  logic            memAck,
   input  logic [31:0]     memRData,
   output logic            wbValid,
   output logic [31:0]     wbPc,
   output logic [5:0]      wbROBNum,
   output logic [5:0]      wbDestReg,
   output logic [31:0]     wbData,
   output logic [CntW-1:0] sbCount,
   output logic            sbEmpty
);

   sched_state_e              state_q, state_d;
   store_entry_t              ret0, ret1, head;
   logic [CntW-1:0]           sb_count;
   logic                      sb_empty, push_ready, pop;
   logic [SB_DEPTH-1:0]       entry_valid;
   logic [SB_DEPTH-1:0][31:0] entry_addr;
   logic                      hazard, age_hit, store_win, load_go, store_go, load_done;

   logic [31:0] mem_addr_q, mem_wdata_q, pc_q, wb_pc_q, wb_data_q;
   logic        mem_size_q, wb_valid_q;
   logic [5:0]  rob_q, dest_q, wb_rob_q, wb_dest_q;

   assign ret0 = '{addr: stRetAddr0, data: stRetData0, size: stRetSize0};
   assign ret1 = '{addr: stRetAddr1, data: stRetData1, size: stRetSize1};

   store_commit_fifo #(
      .SB_DEPTH (SB_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rstn        (rstn),
      .push_valid  (stRetValid),
      .push_entry0 (ret0),
      .push_entry1 (ret1),
      .pop         (pop),
      .head        (head),
      .count       (sb_count),
      .push_ready  (push_ready),
      .entry_valid (entry_valid),
      .entry_addr  (entry_addr)
   );

   // Word-granular compare: a byte store anywhere in the word blocks the load.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (entry_valid[i] && (entry_addr[i][31:2] == ldAddr[31:2])) hazard = 1'b1;
      end
   end

   assign sb_empty  = (sb_count == '0);
   assign store_win = !sb_empty &&
                      (!ldValid || (sb_count >= CntW'(HIGH_WM)) || hazard || age_hit);
   assign load_go   = (state_q == StIdle) && ldValid && !store_win;
   assign store_go  = (state_q == StIdle) && store_win;
   assign pop       = (state_q == StStoreWait) && memAck;
   assign load_done = (state_q == StLoadWait) && memAck;

`ifdef MEMSCHED_AGING_EN
   localparam int unsigned AgeW = $clog2(AGE_LIMIT + 1);
   logic [AgeW-1:0] age_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         age_q <= '0;
      end else if (sb_empty || store_go) begin
         age_q <= '0;
      end else if (load_go && (age_q < AgeW'(AGE_LIMIT))) begin
         age_q <= age_q + AgeW'(1);
      end
   end

   assign age_hit = (age_q >= AgeW'(AGE_LIMIT));
`else
   assign age_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (store_go) state_d = StStoreWait;
            else if (load_go) state_d = StLoadWait;
         end
         StLoadWait, StStoreWait: begin
            if (memAck) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= StIdle;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_size_q  <= MEM_SIZE_WORD;
         pc_q        <= '0;
         rob_q       <= '0;
         dest_q      <= '0;
         wb_valid_q  <= 1'b0;
         wb_pc_q     <= '0;
         wb_rob_q    <= '0;
         wb_dest_q   <= '0;
         wb_data_q   <= '0;
      end else begin
         state_q    <= state_d;
         wb_valid_q <= load_done;
         if (store_go) begin
            mem_addr_q  <= head.addr;
            mem_wdata_q <= head.data;
            mem_size_q  <= head.size;
         end else if (load_go) begin
            mem_addr_q  <= ldAddr;
            mem_wdata_q <= '0;
            mem_size_q  <= MEM_SIZE_WORD;
            pc_q        <= ldPc;
            rob_q       <= ldROBNum;
            dest_q      <= ldDestReg;
         end
         if (load_done) begin
            wb_pc_q   <= pc_q;
            wb_rob_q  <= rob_q;
            wb_dest_q <= dest_q;
            wb_data_q <= memRData;
         end
      end
   end

   assign ldReady    = load_go;
   assign stRetReady = push_ready;
   assign memReq     = (state_q != StIdle);
   assign memWe      = (state_q == StStoreWait);
   assign memAddr    = mem_addr_q;
   assign memWData   = mem_wdata_q;
   assign memSize    = mem_size_q;
   assign wbValid    = wb_valid_q;
   assign wbPc       = wb_pc_q;
   assign wbROBNum   = wb_rob_q;
   assign wbDestReg  = wb_dest_q;
   assign wbData     = wb_data_q;
   assign sbCount    = sb_count;
   assign sbEmpty    = sb_empty;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed self-checking bench for mem_port_scheduler with a delay-programmable memory responder.
module tb_mem_port_scheduler;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ldValid, ldReady;
   logic [31:0] ldPc, ldAddr;
   logic [5:0]  ldROBNum, ldDestReg;
   logic [1:0]  stRetValid;
   logic [31:0] stRetAddr0, stRetAddr1, stRetData0, stRetData1;
   logic        stRetSize0, stRetSize1, stRetReady;
   logic        memReq, memWe, memSize, memAck;
   logic [31:0] memAddr, memWData, memRData;
   logic        wbValid;
   logic [31:0] wbPc, wbData;
   logic [5:0]  wbROBNum, wbDestReg;
   logic [3:0]  sbCount;
   logic        sbEmpty;

   int          n_checks = 0;
   int          n_fail = 0;
   int          ack_delay = 0;
   int          ack_cnt = 0;
   int          proto_viol = 0;
   logic [31:0] rdata = '0;
   logic [64:0] txq[$];  // {we, addr, wdata} of each acknowledged transaction

   mem_port_scheduler #(
      .SB_DEPTH  (8),
      .HIGH_WM   (6),
      .AGE_LIMIT (4)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .ldValid    (ldValid),
      .ldPc       (ldPc),
      .ldAddr     (ldAddr),
      .ldROBNum   (ldROBNum),
      .ldDestReg  (ldDestReg),
      .ldReady    (ldReady),
      .stRetValid (stRetValid),
      .stRetAddr0 (stRetAddr0),
      .stRetAddr1 (stRetAddr1),
      .stRetData0 (stRetData0),
      .stRetData1 (stRetData1),
      .stRetSize0 (stRetSize0),
      .stRetSize1 (stRetSize1),
      .stRetReady (stRetReady),
      .memReq     (memReq),
      .memWe      (memWe),
      .memAddr    (memAddr),
      .memWData   (memWData),
      .memSize    (memSize),
      .memAck     (memAck),
      .memRData   (memRData),
      .wbValid    (wbValid),
      .wbPc       (wbPc),
      .wbROBNum   (wbROBNum),
      .wbDestReg  (wbDestReg),
      .wbData     (wbData),
      .sbCount    (sbCount),
      .sbEmpty    (sbEmpty)
   );

   always #5 clk = ~clk;

   // Memory model: acks ack_delay cycles after memReq first appears, for one cycle.
   initial begin
      memAck = 1'b0;
      memRData = '0;
      forever begin
         @(negedge clk);
         memRData = rdata;
         if (memAck) begin
            memAck = 1'b0;
            ack_cnt = 0;
         end else if (memReq) begin
            if (ack_cnt >= ack_delay) memAck = 1'b1;
            else ack_cnt++;
         end else begin
            ack_cnt = 0;
         end
      end
   end

   always @(posedge clk) begin
      if (rstn && memReq && memAck) txq.push_back({memWe, memAddr, memWData});
      if (rstn && (stRetValid != 2'b00) && !stRetReady) begin
         proto_viol++;
         $display("protocol violation: store push while stRetReady=0 at %0t", $time);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      ldValid = 1'b0;
      stRetValid = 2'b00;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drain(input int bound);
      bit done = 0;
      ldValid = 1'b0;
      stRetValid = 2'b00;
      for (int i = 0; i < bound && !done; i++) begin
         step();
         if (sbEmpty && !memReq) done = 1;
      end
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_timeout: sbCount=%0d expected 0 within %0d cycles", sbCount, bound);
      end
      idle(2);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      ldValid = 0; ldPc = 0; ldAddr = 0; ldROBNum = 0; ldDestReg = 0;
      stRetValid = 0; stRetAddr0 = 0; stRetAddr1 = 0; stRetData0 = 0; stRetData1 = 0;
      stRetSize0 = 0; stRetSize1 = 0;
      step();
      step();
      n_checks++;
      if (memReq !== 1'b0) begin n_fail++; $display("FAIL reset_memReq: got %b expected 0", memReq); end
      n_checks++;
      if (ldReady !== 1'b0) begin n_fail++; $display("FAIL reset_ldReady: got %b expected 0", ldReady); end
      n_checks++;
      if (stRetReady !== 1'b1) begin n_fail++; $display("FAIL reset_stRetReady: got %b expected 1", stRetReady); end
      n_checks++;
      if (sbEmpty !== 1'b1 || sbCount !== 4'd0) begin
         n_fail++; $display("FAIL reset_fifo: sbEmpty=%b sbCount=%0d expected 1/0", sbEmpty, sbCount);
      end
      n_checks++;
      if (wbValid !== 1'b0 || memWe !== 1'b0 || memAddr !== 32'h0 || wbData !== 32'h0) begin
         n_fail++; $display("FAIL reset_outputs: wbValid=%b memWe=%b memAddr=%h wbData=%h expected zeros", wbValid, memWe, memAddr, wbData);
      end
      rstn = 1'b1;
      idle(2);
   endtask

   task automatic test_single_load();
      ack_delay = 2;
      rdata = 32'h46;
      step();
      ldValid = 1; ldAddr = 32'h8; ldPc = 32'h1000; ldROBNum = 6'd5; ldDestReg = 6'd12;
      #1;
      n_checks++;
      if (ldReady !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b expected 1", ldReady); end
      step();  // t+1
      ldValid = 0;
      n_checks++;
      if (memReq !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h8) begin
         n_fail++; $display("FAIL load_req: memReq=%b memWe=%b memAddr=%h expected 1/0/00000008", memReq, memWe, memAddr);
      end
      step();  // t+2
      step();  // t+3, ack cycle
      n_checks++;
      if (wbValid !== 1'b0) begin n_fail++; $display("FAIL load_wb_early: wbValid=%b expected 0", wbValid); end
      step();  // t+4
      n_checks++;
      if (wbValid !== 1'b1 || wbData !== 32'h46 || wbROBNum !== 6'd5 || wbDestReg !== 6'd12 || wbPc !== 32'h1000) begin
         n_fail++; $display("FAIL load_wb: wbValid=%b data=%h rob=%0d dest=%0d pc=%h expected 1/46/5/12/1000", wbValid, wbData, wbROBNum, wbDestReg, wbPc);
      end
      step();
      n_checks++;
      if (wbValid !== 1'b0) begin n_fail++; $display("FAIL load_wb_pulse: wbValid=%b expected 0", wbValid); end
      idle(2);
   endtask

   task automatic test_two_stores();
      bit done = 0;
      ack_delay = 1;
      txq.delete();
      step();
      stRetValid = 2'b11;
      stRetAddr0 = 32'h4; stRetData0 = 32'h23; stRetAddr1 = 32'h8; stRetData1 = 32'h46;
      step();
      stRetValid = 2'b00;
      n_checks++;
      if (sbCount !== 4'd2) begin n_fail++; $display("FAIL two_stores_count: sbCount=%0d expected 2", sbCount); end
      for (int i = 0; i < 30 && !done; i++) begin
         step();
         if (sbEmpty && !memReq && txq.size() >= 2) done = 1;
      end
      n_checks++;
      if (done !== 1'b1 || txq.size() != 2) begin
         n_fail++; $display("FAIL two_stores_drain: done=%b txns=%0d expected 1/2", done, txq.size());
      end else begin
         n_checks++;
         if (txq[0] !== {1'b1, 32'h4, 32'h23}) begin
            n_fail++; $display("FAIL two_stores_first: got %h expected %h", txq[0], {1'b1, 32'h4, 32'h23});
         end
         n_checks++;
         if (txq[1] !== {1'b1, 32'h8, 32'h46}) begin
            n_fail++; $display("FAIL two_stores_second: got %h expected %h", txq[1], {1'b1, 32'h8, 32'h46});
         end
      end
      idle(2);
   endtask

   task automatic test_hazard();
      bit accepted = 0;
      bit wb_seen = 0;
      ack_delay = 1;
      rdata = 32'h23;
      txq.delete();
      step();
      stRetValid = 2'b01; stRetAddr0 = 32'h4; stRetData0 = 32'h23;
      step();
      stRetValid = 2'b00;
      ldValid = 1; ldAddr = 32'h4; ldPc = 32'h2000; ldROBNum = 6'd7; ldDestReg = 6'd3;
      #1;
      n_checks++;
      if (ldReady !== 1'b0) begin n_fail++; $display("FAIL hazard_block: ldReady=%b expected 0", ldReady); end
      for (int i = 0; i < 20 && !accepted; i++) begin
         step();
         if (ldReady) begin
            accepted = 1;
            n_checks++;
            if (sbCount !== 4'd0 || txq.size() != 1) begin
               n_fail++; $display("FAIL hazard_order: sbCount=%0d txns=%0d at load accept expected 0/1", sbCount, txq.size());
            end
         end
      end
      n_checks++;
      if (accepted !== 1'b1) begin n_fail++; $display("FAIL hazard_accept: accepted=%b expected 1", accepted); end
      step();
      ldValid = 0;
      for (int i = 0; i < 10 && !wb_seen; i++) begin
         if (wbValid) begin
            wb_seen = 1;
            n_checks++;
            if (wbData !== 32'h23 || wbROBNum !== 6'd7) begin
               n_fail++; $display("FAIL hazard_wb: data=%h rob=%0d expected 23/7", wbData, wbROBNum);
            end
         end
         step();
      end
      n_checks++;
      if (wb_seen !== 1'b1) begin n_fail++; $display("FAIL hazard_wb_timeout: wbValid never seen, expected 1"); end
      idle(2);
   endtask

   task automatic test_watermark();
      ack_delay = 0;
      txq.delete();
      step();  // c1
      ldValid = 1; ldAddr = 32'h100; ldROBNum = 6'd1; ldDestReg = 6'd1;
      stRetValid = 2'b11; stRetAddr0 = 32'h200; stRetAddr1 = 32'h204;
      #1;
      n_checks++;
      if (ldReady !== 1'b1) begin n_fail++; $display("FAIL wm_load_first: ldReady=%b expected 1", ldReady); end
      step();  // c2
      stRetAddr0 = 32'h208; stRetAddr1 = 32'h20C;
      step();  // c3
      stRetAddr0 = 32'h210; stRetAddr1 = 32'h214;
      #1;
      n_checks++;
      if (ldReady !== 1'b1) begin n_fail++; $display("FAIL wm_load_below: ldReady=%b at sbCount=%0d expected 1", ldReady, sbCount); end
      step();  // c4
      stRetValid = 2'b00;
      n_checks++;
      if (sbCount !== 4'd6) begin n_fail++; $display("FAIL wm_count6: sbCount=%0d expected 6", sbCount); end
      step();  // c5
      stRetValid = 2'b01; stRetAddr0 = 32'h218;
      #1;
      n_checks++;
      if (ldReady !== 1'b0 || stRetReady !== 1'b1) begin
         n_fail++; $display("FAIL wm_store_wins: ldReady=%b stRetReady=%b expected 0/1", ldReady, stRetReady);
      end
      step();  // c6
      stRetValid = 2'b00;
      n_checks++;
      if (sbCount !== 4'd7 || stRetReady !== 1'b0) begin
         n_fail++; $display("FAIL wm_count7: sbCount=%0d stRetReady=%b expected 7/0", sbCount, stRetReady);
      end
      n_checks++;
      if (memReq !== 1'b1 || memWe !== 1'b1 || memAddr !== 32'h200) begin
         n_fail++; $display("FAIL wm_store_req: memReq=%b memWe=%b memAddr=%h expected 1/1/00000200", memReq, memWe, memAddr);
      end
      drain(60);
   endtask

   task automatic test_aging();
      ack_delay = 0;
      txq.delete();
      step();  // c1: load granted with the FIFO still empty
      ldValid = 1; ldAddr = 32'h100;
      step();  // c2
      stRetValid = 2'b01; stRetAddr0 = 32'h300; stRetData0 = 32'h77;
      step();  // c3
      stRetValid = 2'b00;
      for (int i = 0; i < 12; i++) step();
      n_checks++;
      if (txq.size() < 6) begin
         n_fail++; $display("FAIL aging_txns: got %0d transactions expected at least 6", txq.size());
      end else begin
         n_checks++;
         if (txq[1][64] !== 1'b0 || txq[2][64] !== 1'b0 || txq[3][64] !== 1'b0 || txq[4][64] !== 1'b0) begin
            n_fail++; $display("FAIL aging_loads: we bits %b%b%b%b expected 0000", txq[1][64], txq[2][64], txq[3][64], txq[4][64]);
         end
`ifdef MEMSCHED_AGING_EN
         n_checks++;
         if (txq[5] !== {1'b1, 32'h300, 32'h77}) begin
            n_fail++; $display("FAIL aging_forced_store: got %h expected %h", txq[5], {1'b1, 32'h300, 32'h77});
         end
`else
         n_checks++;
         if (txq[5][64:32] !== {1'b0, 32'h100}) begin
            n_fail++; $display("FAIL aging_off_load: got %h expected load to 00000100", txq[5][64:32]);
         end
`endif
      end
      drain(40);
   endtask

   task automatic test_overflow_drop();
      int base;
      ack_delay = 20;
      txq.delete();
      step();
      stRetValid = 2'b11; stRetAddr0 = 32'h500; stRetAddr1 = 32'h504;
      step();
      stRetAddr0 = 32'h508; stRetAddr1 = 32'h50C;
      step();
      stRetAddr0 = 32'h510; stRetAddr1 = 32'h514;
      step();
      stRetValid = 2'b01; stRetAddr0 = 32'h518;
      base = proto_viol;
      step();
      n_checks++;
      if (stRetReady !== 1'b0 || sbCount !== 4'd7) begin
         n_fail++; $display("FAIL ovf_full: stRetReady=%b sbCount=%0d expected 0/7", stRetReady, sbCount);
      end
      stRetValid = 2'b11; stRetAddr0 = 32'h51C; stRetAddr1 = 32'h520;
      step();
      stRetValid = 2'b00;
      n_checks++;
      if (sbCount !== 4'd7) begin n_fail++; $display("FAIL ovf_dropped: sbCount=%0d expected 7", sbCount); end
      n_checks++;
      if (proto_viol !== base + 1) begin
         n_fail++; $display("FAIL ovf_flagged: violations=%0d expected %0d", proto_viol, base + 1);
      end
      ack_delay = 0;
      drain(80);
      n_checks++;
      if (txq.size() != 7) begin n_fail++; $display("FAIL ovf_drained: txns=%0d expected 7", txq.size()); end
   endtask

   task automatic test_reset_abort();
      int wb_count = 0;
      ack_delay = 10;
      step();
      ldValid = 1; ldAddr = 32'h100;
      step();
      ldValid = 0;
      stRetValid = 2'b11; stRetAddr0 = 32'h400; stRetAddr1 = 32'h404;
      step();
      stRetValid = 2'b01; stRetAddr0 = 32'h408;
      step();
      stRetValid = 2'b00;
      n_checks++;
      if (sbCount !== 4'd3 || memReq !== 1'b1 || memWe !== 1'b0) begin
         n_fail++; $display("FAIL abort_setup: sbCount=%0d memReq=%b memWe=%b expected 3/1/0", sbCount, memReq, memWe);
      end
      rstn = 1'b0;
      #1;
      n_checks++;
      if (memReq !== 1'b0 || sbCount !== 4'd0 || sbEmpty !== 1'b1) begin
         n_fail++; $display("FAIL abort_immediate: memReq=%b sbCount=%0d sbEmpty=%b expected 0/0/1", memReq, sbCount, sbEmpty);
      end
      step();
      step();
      rstn = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         if (wbValid) wb_count++;
      end
      n_checks++;
      if (wb_count !== 0) begin n_fail++; $display("FAIL abort_no_wb: wbValid pulses=%0d expected 0", wb_count); end
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_two_stores();
      test_hazard();
      test_watermark();
      test_aging();
      test_overflow_drop();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
